// File: rtl/ysyx_25040111_mem_arb.sv
// N-channel memory-port arbiter: picks one master (fixed priority or round-robin),
// registers its command for the downstream port and routes beats/completion back.
module ysyx_25040111_mem_arb #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LW  = 8,
    parameter int RR  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    m_req,
    input  logic [NCH-1:0]    m_wen,
    input  logic [NCH-1:0]    m_sign,
    input  logic [2*NCH-1:0]  m_mask,
    input  logic [NCH*AW-1:0] m_addr,
    input  logic [NCH*DW-1:0] m_wdata,
    input  logic [NCH*LW-1:0] m_tlen,
    output logic [DW-1:0]     m_rdata,
    output logic [NCH-1:0]    m_beat,
    output logic [NCH-1:0]    m_done,
    output logic [NCH-1:0]    grant,
    output logic              s_start,
    output logic              s_wen,
    output logic              s_ren,
    output logic              s_sign,
    output logic [1:0]        s_mask,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    output logic [LW-1:0]     s_tlen,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_valid
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [IW-1:0] cand;
    logic [IW-1:0] win_idx;
    logic          found;
    logic [LW-1:0] cnt;
    logic          beat_hit;
    logic          done_hit;

    logic          win_wen;
    logic          win_sign;
    logic [1:0]    win_mask;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [LW-1:0] win_tlen;

    function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= NCH) sum = sum - NCH;
        return IW'(sum);
    endfunction

    // Search starts at the RR pointer (or channel 0 for fixed priority) and wraps.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = wrap_idx((RR != 0) ? int'(ptr) : 0, k);
            if (!found && m_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_wen   = 1'b0;
        win_sign  = 1'b0;
        win_mask  = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_tlen  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_idx == IW'(i)) begin
                win_wen   = m_wen[i];
                win_sign  = m_sign[i];
                win_mask  = m_mask[2*i +: 2];
                win_addr  = m_addr[AW*i +: AW];
                win_wdata = m_wdata[DW*i +: DW];
                win_tlen  = m_tlen[LW*i +: LW];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_start   = 1'b0;
        beat_hit  = 1'b0;
        done_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_nxt = ISSUE;
            end
            ISSUE: begin
                s_start   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (s_valid) begin
                    beat_hit = s_ren;
                    done_hit = s_wen || (cnt == '0);
                    if (done_hit) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_rdata = s_rdata;
    assign m_beat  = beat_hit ? grant : '0;
    assign m_done  = done_hit ? grant : '0;

    // Command registers only load in IDLE, so master-side changes mid-transaction are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant   <= '0;
            gidx    <= '0;
            ptr     <= '0;
            cnt     <= '0;
            s_wen   <= 1'b0;
            s_ren   <= 1'b0;
            s_sign  <= 1'b0;
            s_mask  <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_tlen  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= {{(NCH-1){1'b0}}, 1'b1} << win_idx;
                        gidx    <= win_idx;
                        s_wen   <= win_wen;
                        s_ren   <= !win_wen;
                        s_sign  <= win_sign;
                        s_mask  <= win_mask;
                        s_addr  <= win_addr;
                        s_wdata <= win_wdata;
                        s_tlen  <= win_wen ? '0 : win_tlen;
                    end
                end
                ISSUE: begin
                    cnt <= s_tlen;
                end
                WAIT: begin
                    if (done_hit) begin
                        grant <= '0;
                        s_wen <= 1'b0;
                        s_ren <= 1'b0;
                        cnt   <= '0;
                        ptr   <= wrap_idx(int'(gidx), 1);
                    end else if (beat_hit) begin
                        cnt <= cnt - LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_mem_arb.sv
// Bench for ysyx_25040111_mem_arb: a 2-channel round-robin instance and a
// 3-channel fixed-priority instance, directed scenarios plus a randomized run.
module tb_ysyx_25040111_mem_arb;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [1:0]  a_req, a_wen, a_sign;
    logic [3:0]  a_mask;
    logic [63:0] a_addr, a_wdata;
    logic [15:0] a_tlen;
    logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
    logic [1:0]  a_beat, a_done, a_grant, a_smask;
    logic        a_start, a_swen, a_sren, a_ssign, a_svalid;
    logic [7:0]  a_stlen;

    logic [2:0]  b_req, b_wen, b_sign;
    logic [5:0]  b_mask;
    logic [95:0] b_addr, b_wdata;
    logic [23:0] b_tlen;
    logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
    logic [2:0]  b_beat, b_done, b_grant;
    logic [1:0]  b_smask;
    logic        b_start, b_swen, b_sren, b_ssign, b_svalid;
    logic [7:0]  b_stlen;

    int checks = 0;
    int failures = 0;

    ysyx_25040111_mem_arb #(.NCH(2), .AW(32), .DW(32), .LW(8), .RR(1)) dut_a (
        .clock(clock), .reset(reset),
        .m_req(a_req), .m_wen(a_wen), .m_sign(a_sign), .m_mask(a_mask),
        .m_addr(a_addr), .m_wdata(a_wdata), .m_tlen(a_tlen),
        .m_rdata(a_rdata), .m_beat(a_beat), .m_done(a_done), .grant(a_grant),
        .s_start(a_start), .s_wen(a_swen), .s_ren(a_sren), .s_sign(a_ssign),
        .s_mask(a_smask), .s_addr(a_saddr), .s_wdata(a_swdata), .s_tlen(a_stlen),
        .s_rdata(a_srdata), .s_valid(a_svalid)
    );

    ysyx_25040111_mem_arb #(.NCH(3), .AW(32), .DW(32), .LW(8), .RR(0)) dut_b (
        .clock(clock), .reset(reset),
        .m_req(b_req), .m_wen(b_wen), .m_sign(b_sign), .m_mask(b_mask),
        .m_addr(b_addr), .m_wdata(b_wdata), .m_tlen(b_tlen),
        .m_rdata(b_rdata), .m_beat(b_beat), .m_done(b_done), .grant(b_grant),
        .s_start(b_start), .s_wen(b_swen), .s_ren(b_sren), .s_sign(b_ssign),
        .s_mask(b_smask), .s_addr(b_saddr), .s_wdata(b_swdata), .s_tlen(b_stlen),
        .s_rdata(b_srdata), .s_valid(b_svalid)
    );

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input int ch, input logic wen, input logic sign, input logic [1:0] mask,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] tlen);
        a_wen[ch]            = wen;
        a_sign[ch]           = sign;
        a_mask[ch*2 +: 2]    = mask;
        a_addr[ch*32 +: 32]  = addr;
        a_wdata[ch*32 +: 32] = wdata;
        a_tlen[ch*8 +: 8]    = tlen;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (a_grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", a_grant); end
        checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", a_start); end
        checks++; if (a_done !== 2'b00 || a_beat !== 2'b00) begin failures++; $display("FAIL reset_done_beat got=%b/%b exp=00/00", a_done, a_beat); end
        checks++; if (a_swen !== 1'b0 || a_sren !== 1'b0) begin failures++; $display("FAIL reset_wen_ren got=%b/%b exp=0/0", a_swen, a_sren); end
        checks++; if (a_saddr !== 32'h0 || a_stlen !== 8'h0 || a_swdata !== 32'h0) begin failures++; $display("FAIL reset_cmd got=%h/%h/%h exp=0", a_saddr, a_stlen, a_swdata); end
        checks++; if (b_grant !== 3'b000 || b_start !== 1'b0) begin failures++; $display("FAIL reset_b got=%b/%b exp=000/0", b_grant, b_start); end
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_read();
        set_a(1, 1'b0, 1'b0, 2'b11, 32'h8000_0010, 32'h0, 8'd0);
        a_req = 2'b10;
        #3;
        checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL single_start_early got=%b exp=0", a_start); end
        next_cycle();
        #3;
        checks++; if (a_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", a_start); end
        checks++; if (a_saddr !== 32'h8000_0010) begin failures++; $display("FAIL single_addr got=%h exp=80000010", a_saddr); end
        checks++; if (a_sren !== 1'b1 || a_swen !== 1'b0 || a_smask !== 2'b11) begin failures++; $display("FAIL single_cmd got=ren%b wen%b mask%b exp=ren1 wen0 mask11", a_sren, a_swen, a_smask); end
        checks++; if (a_grant !== 2'b10) begin failures++; $display("FAIL single_grant got=%b exp=10", a_grant); end
        next_cycle();
        a_svalid = 1'b1;
        a_srdata = 32'hDEAD_BEEF;
        #3;
        checks++; if (a_beat !== 2'b10) begin failures++; $display("FAIL single_beat got=%b exp=10", a_beat); end
        checks++; if (a_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", a_rdata); end
        checks++; if (a_done !== 2'b10) begin failures++; $display("FAIL single_done got=%b exp=10", a_done); end
        next_cycle();
        a_req = 2'b00;
        a_svalid = 1'b0;
        #3;
        checks++; if (a_grant !== 2'b00 || a_sren !== 1'b0 || a_beat !== 2'b00) begin failures++; $display("FAIL single_after got=g%b ren%b beat%b exp=g00 ren0 beat00", a_grant, a_sren, a_beat); end
        next_cycle();
    endtask

    task automatic test_burst_read();
        int beats0, beats1, done_cnt, beats_at_done;
        bit seen_done;
        beats0 = 0; beats1 = 0; done_cnt = 0; beats_at_done = -1; seen_done = 0;
        set_a(0, 1'b0, 1'b1, 2'b01, 32'h8000_2000, 32'h0, 8'd3);
        a_req = 2'b01;
        a_svalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a_srdata = $urandom;
            #3;
            if (a_beat[0]) begin
                beats0++;
                checks++; if (a_rdata !== a_srdata) begin failures++; $display("FAIL burst_rdata got=%h exp=%h", a_rdata, a_srdata); end
            end
            if (a_beat[1]) beats1++;
            if (a_done != 2'b00) begin
                done_cnt++;
                beats_at_done = beats0;
                seen_done = 1;
            end
            next_cycle();
            if (seen_done) a_req = 2'b00;
        end
        a_svalid = 1'b0;
        checks++; if (beats0 !== 4) begin failures++; $display("FAIL burst_beats got=%0d exp=4", beats0); end
        checks++; if (beats1 !== 0) begin failures++; $display("FAIL burst_wrong_ch got=%0d exp=0", beats1); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL burst_done_count got=%0d exp=1", done_cnt); end
        checks++; if (beats_at_done !== 4) begin failures++; $display("FAIL burst_done_on_last got=%0d exp=4", beats_at_done); end
    endtask

    task automatic test_write();
        set_a(1, 1'b1, 1'b0, 2'b11, 32'h8000_0100, 32'h1234_5678, 8'd5);
        a_req = 2'b10;
        a_svalid = 1'b0;
        next_cycle();
        #3;
        checks++; if (a_start !== 1'b1 || a_grant !== 2'b10) begin failures++; $display("FAIL write_start got=s%b g%b exp=s1 g10", a_start, a_grant); end
        checks++; if (a_swen !== 1'b1 || a_sren !== 1'b0) begin failures++; $display("FAIL write_en got=wen%b ren%b exp=wen1 ren0", a_swen, a_sren); end
        checks++; if (a_stlen !== 8'd0) begin failures++; $display("FAIL write_tlen got=%0d exp=0", a_stlen); end
        checks++; if (a_swdata !== 32'h1234_5678) begin failures++; $display("FAIL write_wdata got=%h exp=12345678", a_swdata); end
        next_cycle();
        a_wdata[63:32] = 32'hFFFF_0000;
        a_addr[63:32]  = 32'h0;
        a_req = 2'b00;
        #3;
        checks++; if (a_done !== 2'b00 || a_grant !== 2'b10) begin failures++; $display("FAIL write_hold got=d%b g%b exp=d00 g10", a_done, a_grant); end
        checks++; if (a_swdata !== 32'h1234_5678 || a_saddr !== 32'h8000_0100) begin failures++; $display("FAIL write_cmd_stable got=%h/%h exp=12345678/80000100", a_swdata, a_saddr); end
        next_cycle();
        a_svalid = 1'b1;
        #3;
        checks++; if (a_done !== 2'b10) begin failures++; $display("FAIL write_done got=%b exp=10", a_done); end
        checks++; if (a_beat !== 2'b00) begin failures++; $display("FAIL write_nobeat got=%b exp=00", a_beat); end
        next_cycle();
        a_svalid = 1'b0;
        #3;
        checks++; if (a_grant !== 2'b00 || a_swen !== 1'b0) begin failures++; $display("FAIL write_after got=g%b wen%b exp=g00 wen0", a_grant, a_swen); end
        next_cycle();
    endtask

    task automatic test_rr_alternate();
        logic [1:0] got_g[$];
        int got_c[$];
        logic [1:0] exp_g[3];
        int exp_c[3];
        int done_cyc;
        exp_g = '{2'b01, 2'b10, 2'b01};
        exp_c = '{1, 4, 7};
        done_cyc = -100;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        set_a(0, 1'b0, 1'b0, 2'b11, 32'h8000_0000, 32'h0, 8'd0);
        set_a(1, 1'b0, 1'b0, 2'b11, 32'h8000_0004, 32'h0, 8'd0);
        a_req = 2'b11;
        a_svalid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            a_srdata = $urandom;
            #3;
            if (a_start) begin
                got_g.push_back(a_grant);
                got_c.push_back(c);
            end
            if (c == done_cyc + 1) begin
                checks++; if (a_grant !== 2'b00 || a_start !== 1'b0) begin failures++; $display("FAIL rr_bubble cycle=%0d got=g%b s%b exp=g00 s0", c, a_grant, a_start); end
            end
            if (a_done != 2'b00) done_cyc = c;
            next_cycle();
        end
        a_req = 2'b00;
        a_svalid = 1'b0;
        next_cycle();
        checks++;
        if (got_g.size() != 3) begin
            failures++; $display("FAIL rr_grant_count got=%0d exp=3", got_g.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_g[i] !== exp_g[i] || got_c[i] !== exp_c[i]) begin failures++; $display("FAIL rr_order idx=%0d got=g%b@%0d exp=g%b@%0d", i, got_g[i], got_c[i], exp_g[i], exp_c[i]); end
            end
        end
    endtask

    task automatic test_fixed_priority();
        int starts;
        starts = 0;
        b_wen = 3'b000; b_sign = 3'b001; b_mask = 6'b11_00_01; b_tlen = 24'h0;
        b_addr  = {32'h2000_0080, 32'h0, 32'h1000_0040};
        b_wdata = {32'h5A5A_1111, 32'h0, 32'hA5A5_0000};
        b_req = 3'b101;
        b_svalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            b_srdata = $urandom;
            #3;
            checks++; if (b_grant[2] !== 1'b0 || b_grant[1] !== 1'b0) begin failures++; $display("FAIL fp_grant cycle=%0d got=%b exp=x00 low-only", c, b_grant); end
            if (b_start) begin
                starts++;
                checks++;
                if (b_grant !== 3'b001 || b_saddr !== 32'h1000_0040 || b_sren !== 1'b1 || b_swen !== 1'b0 ||
                    b_ssign !== 1'b1 || b_smask !== 2'b01 || b_swdata !== 32'hA5A5_0000 || b_stlen !== 8'd0) begin
                    failures++;
                    $display("FAIL fp_cmd got=g%b a%h r%b w%b s%b m%b d%h t%0d exp=g001 a10000040 r1 w0 s1 m01 da5a50000 t0",
                             b_grant, b_saddr, b_sren, b_swen, b_ssign, b_smask, b_swdata, b_stlen);
                end
            end
            if (b_beat != 3'b000) begin
                checks++; if (b_beat !== 3'b001 || b_done !== 3'b001 || b_rdata !== b_srdata) begin failures++; $display("FAIL fp_beat got=b%b d%b r%h exp=b001 d001 r%h", b_beat, b_done, b_rdata, b_srdata); end
            end
            next_cycle();
        end
        checks++; if (starts !== 7) begin failures++; $display("FAIL fp_start_count got=%0d exp=7", starts); end
        b_req = 3'b000;
        repeat (3) next_cycle();
        b_svalid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        beats = 0;
        set_a(0, 1'b0, 1'b0, 2'b11, 32'h8000_3000, 32'h0, 8'd3);
        a_req = 2'b01;
        a_svalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            a_srdata = $urandom;
            #3;
            if (a_beat[0]) beats++;
            next_cycle();
        end
        checks++; if (beats !== 2) begin failures++; $display("FAIL rst_pre_beats got=%0d exp=2", beats); end
        reset = 1'b1;
        #1;
        checks++; if (a_grant !== 2'b00 || a_start !== 1'b0) begin failures++; $display("FAIL rst_async_grant got=g%b s%b exp=g00 s0", a_grant, a_start); end
        checks++; if (a_done !== 2'b00 || a_beat !== 2'b00) begin failures++; $display("FAIL rst_async_done got=d%b b%b exp=d00 b00", a_done, a_beat); end
        checks++; if (a_sren !== 1'b0 || a_stlen !== 8'd0) begin failures++; $display("FAIL rst_async_cmd got=ren%b t%0d exp=ren0 t0", a_sren, a_stlen); end
        next_cycle();
        reset = 1'b0;
        a_req = 2'b00;
        a_svalid = 1'b0;
        next_cycle();
        set_a(1, 1'b0, 1'b0, 2'b11, 32'h8000_4000, 32'h0, 8'd0);
        a_req = 2'b10;
        next_cycle();
        #3;
        checks++; if (a_start !== 1'b1 || a_grant !== 2'b10 || a_saddr !== 32'h8000_4000) begin failures++; $display("FAIL rst_fresh_grant got=s%b g%b a%h exp=s1 g10 a80004000", a_start, a_grant, a_saddr); end
        next_cycle();
        a_svalid = 1'b1;
        a_srdata = 32'h0BAD_CAFE;
        #3;
        checks++; if (a_done !== 2'b10 || a_beat !== 2'b10) begin failures++; $display("FAIL rst_fresh_done got=d%b b%b exp=d10 b10", a_done, a_beat); end
        next_cycle();
        a_req = 2'b00;
        a_svalid = 1'b0;
        next_cycle();
    endtask

    task automatic test_random();
        int mo, mph, mleft, mptr, w, idx;
        logic cw, cs;
        logic [1:0] cm, mk, eg, eb, ed;
        logic [31:0] ca, cd;
        logic [7:0] ct;
        logic est, hit;
        reset = 1'b1;
        #3;
        next_cycle();
        reset = 1'b0;
        mo = -1; mph = 0; mleft = 0; mptr = 0;
        cw = 1'b0; cs = 1'b0; cm = 2'b00; ca = 32'h0; cd = 32'h0; ct = 8'h0;
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                case ($urandom_range(0, 2))
                    0:       mk = 2'b00;
                    1:       mk = 2'b01;
                    default: mk = 2'b11;
                endcase
                a_req[ch] = ($urandom_range(0, 9) < 6);
                set_a(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk, $urandom, $urandom, 8'($urandom_range(0, 3)));
            end
            a_svalid = 1'($urandom_range(0, 1));
            a_srdata = $urandom;
            eg  = (mo >= 0) ? (2'b01 << mo) : 2'b00;
            est = (mo >= 0) && (mph == 0);
            hit = (mo >= 0) && (mph == 1) && a_svalid;
            eb  = (hit && !cw) ? eg : 2'b00;
            ed  = (hit && (cw || mleft == 1)) ? eg : 2'b00;
            #3;
            checks++; if (a_grant !== eg || a_start !== est) begin failures++; $display("FAIL rand_grant cycle=%0d got=g%b s%b exp=g%b s%b", c, a_grant, a_start, eg, est); end
            checks++; if (a_beat !== eb || a_done !== ed) begin failures++; $display("FAIL rand_beat cycle=%0d got=b%b d%b exp=b%b d%b", c, a_beat, a_done, eb, ed); end
            checks++; if (a_rdata !== a_srdata) begin failures++; $display("FAIL rand_rdata cycle=%0d got=%h exp=%h", c, a_rdata, a_srdata); end
            checks++;
            if (a_swen !== ((mo >= 0) && cw) || a_sren !== ((mo >= 0) && !cw) || a_saddr !== ca || a_swdata !== cd ||
                a_smask !== cm || a_ssign !== cs || a_stlen !== (cw ? 8'd0 : ct)) begin
                failures++;
                $display("FAIL rand_cmd cycle=%0d got=w%b r%b a%h d%h m%b s%b t%0d exp=w%b r%b a%h d%h m%b s%b t%0d", c,
                         a_swen, a_sren, a_saddr, a_swdata, a_smask, a_ssign, a_stlen,
                         (mo >= 0) && cw, (mo >= 0) && !cw, ca, cd, cm, cs, cw ? 8'd0 : ct);
            end
            if (mo < 0) begin
                w = -1;
                for (int k = 0; k < 2; k++) begin
                    idx = (mptr + k) % 2;
                    if (w < 0 && a_req[idx]) w = idx;
                end
                if (w >= 0) begin
                    mo = w; mph = 0;
                    cw = a_wen[w]; cs = a_sign[w]; cm = a_mask[w*2 +: 2];
                    ca = a_addr[w*32 +: 32]; cd = a_wdata[w*32 +: 32]; ct = a_tlen[w*8 +: 8];
                    mleft = cw ? 1 : int'(ct) + 1;
                end
            end else if (mph == 0) begin
                mph = 1;
            end else if (hit) begin
                if (ed != 2'b00) begin
                    mptr = (mo + 1) % 2;
                    mo = -1;
                end else begin
                    mleft--;
                end
            end
            next_cycle();
        end
        a_req = 2'b00;
        a_svalid = 1'b0;
    endtask

    initial begin
        a_req = '0; a_wen = '0; a_sign = '0; a_mask = '0; a_addr = '0; a_wdata = '0; a_tlen = '0;
        a_srdata = '0; a_svalid = 1'b0;
        b_req = '0; b_wen = '0; b_sign = '0; b_mask = '0; b_addr = '0; b_wdata = '0; b_tlen = '0;
        b_srdata = '0; b_svalid = 1'b0;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        test_reset();
        test_single_read();
        test_burst_read();
        test_write();
        test_rr_alternate();
        test_fixed_priority();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
